// File: rtl/hamming_pack.sv
// Shared definitions for the SECDED (16,11) encoder: FSM encodings, parity masks
// and the data-bit placement helper.
package hamming_pack;

    localparam int unsigned DATA_W  = 11;
    localparam int unsigned CW_W    = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 7;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_RD_LO = 3'd1;
    localparam logic [STATE_W-1:0] S_RD_HI = 3'd2;
    localparam logic [STATE_W-1:0] S_CAPT  = 3'd3;
    localparam logic [STATE_W-1:0] S_WR_LO = 3'd4;
    localparam logic [STATE_W-1:0] S_WR_HI = 3'd5;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd6;

    // Hamming positions covered by p1/p2/p4/p8
    localparam logic [CW_W-1:0] MASK_P1 = 16'hAAAA;
    localparam logic [CW_W-1:0] MASK_P2 = 16'hCCCC;
    localparam logic [CW_W-1:0] MASK_P4 = 16'hF0F0;
    localparam logic [CW_W-1:0] MASK_P8 = 16'hFF00;

    // Scatter b1..b11 into the non-power-of-two positions, parity slots left 0
    function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] pos;
        pos       = '0;
        pos[15:9] = d[10:4];
        pos[7:5]  = d[3:1];
        pos[3]    = d[0];
        return pos;
    endfunction

endpackage

// File: rtl/hamming_enc16.sv
// Combinational SECDED (16,11) encoder; codeword bit k is Hamming position k,
// bit 0 carries overall even parity.
module hamming_enc16
    import hamming_pack::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   cw_c
);

    logic [CW_W-1:0] pos;
    logic [CW_W-1:0] cw;

    always_comb begin
        pos    = place_data(data);
        cw     = pos;
        cw[1]  = ^(pos & MASK_P1);
        cw[2]  = ^(pos & MASK_P2);
        cw[4]  = ^(pos & MASK_P4);
        cw[8]  = ^(pos & MASK_P8);
        cw[0]  = ^cw[15:1];
        cw_c   = cw;
    end

endmodule

// File: rtl/hamming_enc_engine.sv
// Block encoder beside the CPU: reads 11-bit words from data memory, writes
// SECDED codewords back, 5 cycles per word, start/done pulse handshake.
module hamming_enc_engine
    import hamming_pack::*;
#(
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 30,
    parameter int unsigned NUM_WORDS = 15
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [BYTE_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [BYTE_W-1:0] mem_wr_data
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] SRC_B    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_B    = ADDR_W'(DST_BASE);

    logic [STATE_W-1:0] state, nxt_state;
    logic [IDX_W-1:0]   i_q, nxt_i;
    logic [BYTE_W-1:0]  lo_q;
    logic [CW_W-1:0]    cw_q;
    logic [CW_W-1:0]    cw_c;
    logic [ADDR_W-1:0]  ofs;

    logic              nxt_busy, nxt_done, nxt_rd_en, nxt_wr_en;
    logic [ADDR_W-1:0] nxt_addr;
    logic [BYTE_W-1:0] nxt_wr_data;

    // hi byte is consumed straight off the read bus at the CAPT edge
    hamming_enc16 u_enc (
        .data ({mem_rd_data[2:0], lo_q}),
        .cw_c (cw_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            i_q         <= '0;
            lo_q        <= '0;
            cw_q        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            state       <= nxt_state;
            i_q         <= nxt_i;
            busy        <= nxt_busy;
            done        <= nxt_done;
            mem_addr    <= nxt_addr;
            mem_rd_en   <= nxt_rd_en;
            mem_wr_en   <= nxt_wr_en;
            mem_wr_data <= nxt_wr_data;
            if (state == S_RD_HI) lo_q <= mem_rd_data;
            if (state == S_CAPT)  cw_q <= cw_c;
        end
    end

    // Next state and index
    always_comb begin
        nxt_state = state;
        nxt_i     = i_q;
        case (state)
            S_IDLE:  if (start) begin
                         nxt_state = S_RD_LO;
                         nxt_i     = '0;
                     end
            S_RD_LO: nxt_state = S_RD_HI;
            S_RD_HI: nxt_state = S_CAPT;
            S_CAPT:  nxt_state = S_WR_LO;
            S_WR_LO: nxt_state = S_WR_HI;
            S_WR_HI: if (i_q == LAST_IDX) begin
                         nxt_state = S_DONE;
                     end else begin
                         nxt_state = S_RD_LO;
                         nxt_i     = IDX_W'(i_q + 7'd1);
                     end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the state being entered
    always_comb begin
        nxt_busy    = 1'b0;
        nxt_done    = 1'b0;
        nxt_rd_en   = 1'b0;
        nxt_wr_en   = 1'b0;
        nxt_addr    = '0;
        nxt_wr_data = '0;
        ofs         = ADDR_W'({nxt_i, 1'b0});
        case (nxt_state)
            S_RD_LO: begin
                nxt_busy  = 1'b1;
                nxt_rd_en = 1'b1;
                nxt_addr  = ADDR_W'(SRC_B + ofs);
            end
            S_RD_HI: begin
                nxt_busy  = 1'b1;
                nxt_rd_en = 1'b1;
                nxt_addr  = ADDR_W'(SRC_B + ofs + 8'd1);
            end
            S_CAPT:  nxt_busy = 1'b1;
            S_WR_LO: begin
                nxt_busy    = 1'b1;
                nxt_wr_en   = 1'b1;
                nxt_addr    = ADDR_W'(DST_B + ofs);
                nxt_wr_data = cw_c[7:0];
            end
            S_WR_HI: begin
                nxt_busy    = 1'b1;
                nxt_wr_en   = 1'b1;
                nxt_addr    = ADDR_W'(DST_B + ofs + 8'd1);
                nxt_wr_data = cw_q[15:8];
            end
            S_DONE:  nxt_done = 1'b1;
            default: nxt_busy = 1'b0;
        endcase
    end

endmodule
